// File: rtl/width_variant_arb_pkg.sv
// Shared types and helpers for the frame-granular round-robin stream arbiter.
package width_variant_arb_pkg;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_t;

   localparam logic RST_ACTIVE = 1'b0;

   // Source-index width never collapses to zero bits, even for a single requester.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/width_variant_stream_arb_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping to the bottom.
module rr_priority_pick #(
   parameter int INPUTS = 2,
   parameter int SRC_W  = 1
) (
   input  logic [INPUTS-1:0] req,
   input  logic [SRC_W-1:0]  ptr,
   output logic              any,
   output logic [SRC_W-1:0]  idx
);

   logic [2*INPUTS-1:0] dbl;
   logic [2*INPUTS-1:0] masked;
   logic                found;

   assign dbl = {req, req};

   // The lower copy is masked below ptr, so the upper copy supplies the wrap-around.
   always_comb begin
      masked = '0;
      any    = |req;
      idx    = '0;
      found  = 1'b0;
      for (int i = 0; i < 2 * INPUTS; i++) begin
         masked[i] = dbl[i] && ((i >= INPUTS) || (i >= int'(ptr)));
      end
      for (int i = 0; i < 2 * INPUTS; i++) begin
         if (!found && masked[i]) begin
            found = 1'b1;
            idx   = SRC_W'(i % INPUTS);
         end
      end
   end

endmodule

// File: rtl/width_variant_stream_arb.sv
// Frame-granular round-robin arbiter feeding one registered output stage.
module width_variant_stream_arb
   import width_variant_arb_pkg::*;
#(
   parameter  int DATA_WIDTH = 2,
   parameter  int INPUTS     = 2,
   localparam int SRC_W      = clog2_min1(INPUTS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [INPUTS-1:0]            en,
   input  logic [INPUTS*DATA_WIDTH-1:0] dataIn_data,
   input  logic [INPUTS-1:0]            dataIn_last,
   input  logic [INPUTS-1:0]            dataIn_vld,
   output logic [INPUTS-1:0]            dataIn_rd,
   output logic [DATA_WIDTH-1:0]        dataOut_data,
   output logic                         dataOut_last,
   output logic [SRC_W-1:0]             dataOut_src,
   output logic                         dataOut_vld,
   input  logic                         dataOut_rd
);

   arb_state_t             state_q, state_d;
   logic [SRC_W-1:0]       owner_q, owner_d;
   logic [SRC_W-1:0]       ptr_q, ptr_d;
   logic [SRC_W-1:0]       pick;
   logic [SRC_W-1:0]       sel;
   logic [SRC_W-1:0]       sel_next;
   logic [INPUTS-1:0]      cand;
   logic                   any;
   logic                   can_load;
   logic                   accept;
   logic                   sel_last;
   logic [DATA_WIDTH-1:0]  sel_data;

   assign cand     = dataIn_vld & en;
   assign can_load = !dataOut_vld || dataOut_rd;
   assign sel      = (state_q == LOCKED) ? owner_q : pick;
   assign sel_data = dataIn_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_last = dataIn_last[sel];
   assign sel_next = (int'(sel) == INPUTS - 1) ? '0 : sel + SRC_W'(1);
   assign accept   = |(dataIn_rd & dataIn_vld);

   rr_priority_pick #(
      .INPUTS (INPUTS),
      .SRC_W  (SRC_W)
   ) u_pick (
      .req (cand),
      .ptr (ptr_q),
      .any (any),
      .idx (pick)
   );

   always_ff @(posedge clk) begin
      if (rst_n == RST_ACTIVE) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   // While locked, en is ignored for the owner so an open frame always runs to its last beat.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      dataIn_rd = '0;
      case (state_q)
         IDLE: begin
            for (int i = 0; i < INPUTS; i++) begin
               dataIn_rd[i] = any && can_load && (SRC_W'(i) == pick);
            end
         end
         LOCKED: begin
            for (int i = 0; i < INPUTS; i++) begin
               dataIn_rd[i] = can_load && (SRC_W'(i) == owner_q);
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst_n == RST_ACTIVE) begin
         dataIn_rd = '0;
      end
      if (accept) begin
         if (sel_last) begin
            state_d = IDLE;
            ptr_d   = sel_next;
         end else begin
            state_d = LOCKED;
            owner_d = sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n == RST_ACTIVE) begin
         dataOut_vld  <= 1'b0;
         dataOut_data <= '0;
         dataOut_last <= 1'b0;
         dataOut_src  <= '0;
      end else if (accept) begin
         dataOut_vld  <= 1'b1;
         dataOut_data <= sel_data;
         dataOut_last <= sel_last;
         dataOut_src  <= sel;
      end else if (dataOut_rd) begin
         dataOut_vld  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_width_variant_stream_arb.sv
// Directed bench for width_variant_stream_arb with DATA_WIDTH=2, INPUTS=2.
module tb_width_variant_stream_arb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] en;
   logic [3:0] dataIn_data;
   logic [1:0] dataIn_last;
   logic [1:0] dataIn_vld;
   logic [1:0] dataIn_rd;
   logic [1:0] dataOut_data;
   logic       dataOut_last;
   logic       dataOut_src;
   logic       dataOut_vld;
   logic       dataOut_rd;

   int checkCount = 0;
   int errorCount = 0;
   int inCount    = 0;
   int outCount   = 0;

   width_variant_stream_arb #(
      .DATA_WIDTH (2),
      .INPUTS     (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .dataIn_data  (dataIn_data),
      .dataIn_last  (dataIn_last),
      .dataIn_vld   (dataIn_vld),
      .dataIn_rd    (dataIn_rd),
      .dataOut_data (dataOut_data),
      .dataOut_last (dataOut_last),
      .dataOut_src  (dataOut_src),
      .dataOut_vld  (dataOut_vld),
      .dataOut_rd   (dataOut_rd)
   );

   always #5 clk = ~clk;

   // Transfers are tallied mid-cycle, when the values that the next edge will act on are stable.
   always @(negedge clk) begin
      if (rst_n) begin
         inCount  = inCount + int'(dataIn_rd[0] & dataIn_vld[0]) + int'(dataIn_rd[1] & dataIn_vld[1]);
         outCount = outCount + int'(dataOut_vld & dataOut_rd);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [1:0] e, input logic [1:0] l,
                                input logic [1:0] d0, input logic [1:0] d1, input logic ordy);
      dataIn_vld  = v;
      en          = e;
      dataIn_last = l;
      dataIn_data = {d1, d0};
      dataOut_rd  = ordy;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 1'b1);
      repeat (3) step();
      checkOutput("rst_vld", 32'(dataOut_vld), 32'd0);
      checkOutput("rst_rd", 32'(dataIn_rd), 32'd0);
      checkOutput("rst_src", 32'(dataOut_src), 32'd0);
      checkOutput("rst_data", 32'(dataOut_data), 32'd0);

      rst_n = 1'b1;
      #1;
      checkOutput("first_grant", 32'(dataIn_rd), 32'b01);
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("rot_vld", 32'(dataOut_vld), 32'd1);
         checkOutput("rot_data", 32'(dataOut_data), (i % 2 == 0) ? 32'd1 : 32'd2);
         checkOutput("rot_src", 32'(dataOut_src), 32'(i % 2));
      end
      applyStimulus(2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 1'b1);
      step();
      checkOutput("drain_vld", 32'(dataOut_vld), 32'd0);
      checkOutput("drain_hold", 32'(dataOut_data), 32'd2);

      applyStimulus(2'b11, 2'b11, 2'b10, 2'd1, 2'd3, 1'b1);
      checkOutput("lock_rd1", 32'(dataIn_rd), 32'b01);
      step();
      checkOutput("lock_d1", 32'(dataOut_data), 32'd1);
      checkOutput("lock_s1", 32'(dataOut_src), 32'd0);
      checkOutput("lock_l1", 32'(dataOut_last), 32'd0);
      applyStimulus(2'b11, 2'b11, 2'b10, 2'd2, 2'd3, 1'b1);
      checkOutput("lock_rd2", 32'(dataIn_rd), 32'b01);
      step();
      checkOutput("lock_d2", 32'(dataOut_data), 32'd2);
      checkOutput("lock_s2", 32'(dataOut_src), 32'd0);
      applyStimulus(2'b11, 2'b11, 2'b11, 2'd3, 2'd3, 1'b1);
      checkOutput("lock_rd3", 32'(dataIn_rd), 32'b01);
      step();
      checkOutput("lock_d3", 32'(dataOut_data), 32'd3);
      checkOutput("lock_l3", 32'(dataOut_last), 32'd1);
      checkOutput("lock_s3", 32'(dataOut_src), 32'd0);
      applyStimulus(2'b10, 2'b11, 2'b11, 2'd3, 2'd3, 1'b1);
      checkOutput("after_lock_rd", 32'(dataIn_rd), 32'b10);
      step();
      checkOutput("after_lock_src", 32'(dataOut_src), 32'd1);

      applyStimulus(2'b01, 2'b11, 2'b00, 2'd1, 2'd0, 1'b1);
      checkOutput("bp_rd0", 32'(dataIn_rd), 32'b01);
      step();
      checkOutput("bp_d1", 32'(dataOut_data), 32'd1);
      applyStimulus(2'b01, 2'b11, 2'b00, 2'd2, 2'd0, 1'b0);
      checkOutput("bp_rd_stall", 32'(dataIn_rd), 32'b00);
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("bp_hold_data", 32'(dataOut_data), 32'd1);
         checkOutput("bp_hold_vld", 32'(dataOut_vld), 32'd1);
         checkOutput("bp_hold_rd", 32'(dataIn_rd), 32'b00);
      end
      applyStimulus(2'b01, 2'b11, 2'b00, 2'd2, 2'd0, 1'b1);
      checkOutput("bp_release_rd", 32'(dataIn_rd), 32'b01);
      step();
      checkOutput("bp_d2", 32'(dataOut_data), 32'd2);
      applyStimulus(2'b01, 2'b11, 2'b00, 2'd3, 2'd0, 1'b1);
      step();
      checkOutput("bp_d3", 32'(dataOut_data), 32'd3);
      applyStimulus(2'b01, 2'b11, 2'b01, 2'd0, 2'd0, 1'b1);
      step();
      checkOutput("bp_d4", 32'(dataOut_data), 32'd0);
      checkOutput("bp_l4", 32'(dataOut_last), 32'd1);
      applyStimulus(2'b00, 2'b11, 2'b00, 2'd0, 2'd0, 1'b1);
      step();
      checkOutput("bp_drain_vld", 32'(dataOut_vld), 32'd0);
      checkOutput("in_count", 32'(inCount), 32'd12);
      checkOutput("out_count", 32'(outCount), 32'd12);

      applyStimulus(2'b11, 2'b10, 2'b11, 2'd1, 2'd2, 1'b1);
      checkOutput("mask_rd_a", 32'(dataIn_rd), 32'b10);
      step();
      checkOutput("mask_src_a", 32'(dataOut_src), 32'd1);
      checkOutput("mask_rd_b", 32'(dataIn_rd), 32'b10);
      step();
      checkOutput("mask_src_b", 32'(dataOut_src), 32'd1);
      checkOutput("mask_data_b", 32'(dataOut_data), 32'd2);

      applyStimulus(2'b11, 2'b11, 2'b10, 2'd1, 2'd2, 1'b1);
      checkOutput("mlock_rd1", 32'(dataIn_rd), 32'b01);
      step();
      checkOutput("mlock_d1", 32'(dataOut_data), 32'd1);
      applyStimulus(2'b11, 2'b10, 2'b10, 2'd2, 2'd2, 1'b1);
      checkOutput("mlock_rd2", 32'(dataIn_rd), 32'b01);
      step();
      checkOutput("mlock_d2", 32'(dataOut_data), 32'd2);
      checkOutput("mlock_s2", 32'(dataOut_src), 32'd0);
      applyStimulus(2'b11, 2'b10, 2'b11, 2'd3, 2'd2, 1'b1);
      checkOutput("mlock_rd3", 32'(dataIn_rd), 32'b01);
      step();
      checkOutput("mlock_d3", 32'(dataOut_data), 32'd3);
      checkOutput("mlock_l3", 32'(dataOut_last), 32'd1);

      applyStimulus(2'b10, 2'b11, 2'b00, 2'd0, 2'd1, 1'b1);
      checkOutput("rmf_rd1", 32'(dataIn_rd), 32'b10);
      step();
      checkOutput("rmf_s1", 32'(dataOut_src), 32'd1);
      applyStimulus(2'b10, 2'b11, 2'b00, 2'd0, 2'd2, 1'b1);
      step();
      checkOutput("rmf_d2", 32'(dataOut_data), 32'd2);
      rst_n = 1'b0;
      applyStimulus(2'b11, 2'b11, 2'b11, 2'd1, 2'd2, 1'b1);
      checkOutput("rmf_rd_in_rst", 32'(dataIn_rd), 32'b00);
      step();
      checkOutput("rmf_vld", 32'(dataOut_vld), 32'd0);
      checkOutput("rmf_src", 32'(dataOut_src), 32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("rmf_regrant", 32'(dataIn_rd), 32'b01);
      step();
      checkOutput("rmf_next_src", 32'(dataOut_src), 32'd0);
      checkOutput("rmf_next_data", 32'(dataOut_data), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/width_variant_stream_arb.md
Name: width_variant_stream_arb

Overview:
- Shares one DATA_WIDTH-wide stream datapath (a parametrized pass-through unit variant) among INPUTS requesters.
- Arbitrates round-robin at frame granularity: a grant holds until the beat carrying last=1 is accepted.
- Drives a single registered output stage carrying data, last and the source index.
- Sits directly in front of the shared pass-through unit, one instance per width variant selected by the generate wrapper.

Parameters:
- DATA_WIDTH, 2, bit width of each data beat; legal 1..64.
- INPUTS, 2, number of requesting streams; legal 1..16.
- SRC_W, max(1, clog2(INPUTS)), width of the source-index field; derived, not overridable.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  INPUTS  per-input enable mask; bit i=0 excludes input i from new grants.
- dataIn_data  in  INPUTS*DATA_WIDTH  beat data; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- dataIn_last  in  INPUTS  end-of-frame flag per input.
- dataIn_vld  in  INPUTS  beat valid per input.
- dataIn_rd  out  INPUTS  beat ready per input.
- dataOut_data  out  DATA_WIDTH  registered beat data.
- dataOut_last  out  1  registered end-of-frame flag.
- dataOut_src  out  SRC_W  index of the input that supplied the current beat.
- dataOut_vld  out  1  output beat valid.
- dataOut_rd  in  1  downstream ready.

Behaviour:
- Handshake: a beat transfers on a rising edge where vld=1 and rd=1. Valid must not depend combinationally on ready. dataIn_rd may depend combinationally on dataIn_vld, en and dataOut_rd.
- Reset (rst_n=0 at an edge) clears: dataOut_vld=0, dataOut_data=0, dataOut_last=0, dataOut_src=0, state=IDLE, ptr=0.
  - A frame interrupted by reset is dropped; no recovery beat is emitted.
  - dataIn_rd=0 while rst_n=0.
- Output register: can_load = !dataOut_vld | dataOut_rd.
  - Loads when an input beat is accepted.
  - Otherwise, if dataOut_rd=1, clears dataOut_vld; data, last and src hold their old values.
  - Throughput is 1 beat/cycle; latency from input accept to dataOut_vld=1 is 1 cycle.
- State machine (state, owner, ptr):
  - IDLE:
    - cand = dataIn_vld & en.
    - pick = first set bit of cand, scanning from ptr upward with wrap.
    - If cand != 0 and can_load: dataIn_rd[pick]=1 in the same cycle and the beat is accepted.
    - If the accepted beat has last=1: stay IDLE, ptr <= (pick+1) mod INPUTS.
    - If the accepted beat has last=0: go to LOCKED, owner <= pick.
    - If cand == 0 or !can_load: all dataIn_rd=0 and ptr holds.
  - LOCKED:
    - dataIn_rd[owner] = can_load; all other rd=0.
    - en is ignored for the owner, so a frame is never truncated.
    - Accepting a beat with last=1 returns to IDLE with ptr <= (owner+1) mod INPUTS.
    - Accepting a beat with last=0 stays LOCKED.
    - If the owner's dataIn_vld=0: hold LOCKED and insert a bubble.
- At most one dataIn_rd bit is high per cycle.
- Single-beat frames (last=1 on the first beat) never enter LOCKED. Back-to-back single-beat frames rotate the grant every cycle.
- Simultaneous events on one edge: accepting a new beat while the downstream takes the current beat is a normal full-rate transfer.
- INPUTS=1: ptr is constant 0; the block degenerates to a registered pipeline stage with a frame lock.
- ptr wrap: ptr = INPUTS-1 followed by a frame end sets ptr to 0.

Decomposition:
- Package width_variant_arb_pkg:
  - state enum {IDLE, LOCKED};
  - function clog2_min1 for SRC_W;
  - constant RST_ACTIVE=1'b0.
- Sub-module rr_priority_pick (combinational):
  - inputs req[INPUTS] and ptr[SRC_W];
  - outputs any and idx[SRC_W];
  - implemented as a double-width request vector with a masked priority encoder.
- The top level holds the state machine, the output register and the data mux.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all dataIn_vld=1 → dataOut_vld=0, dataIn_rd=00, dataOut_src=0. After release, the first grant goes to input 0.
- Rotation (DATA_WIDTH=2, INPUTS=2):
  - Both inputs send continuous single-beat frames: in0 data 2'b01, in1 data 2'b10, dataOut_rd=1.
  - Expected output data sequence 01,10,01,10 with src 0,1,0,1.
  - First dataOut_vld=1 appears 1 cycle after the first accept.
- Frame lock:
  - in0 sends a 3-beat frame (data 1,2,3, last on 3) while in1 is valid throughout.
  - Output: src=0 for 3 beats, then in1's beat.
  - dataIn_rd[1]=0 throughout the in0 frame.
- Backpressure:
  - Hold dataOut_rd=0 for 4 cycles mid-frame → dataOut_data is stable and dataIn_rd=00 after the register fills.
  - Release → no beat lost or duplicated; output count equals input count.
- Mask:
  - en=2'b10 with both inputs valid → only in1 is granted.
  - Drop en[0]... while in0 is LOCKED (en=2'b10 set mid-frame) → in0's frame still completes to last.
- Reset mid-frame: assert rst_n=0 after 2 of 4 beats → next edge gives dataOut_vld=0 and state IDLE; the next grant comes from ptr=0.
